// File: rtl/emergency_preempt_ctrl.sv
// emergency_preempt_ctrl: two-phase NS/EW signal controller with ambulance preemption; define PREEMPT_MIN_GREEN_EN to hold off truncation until MIN_GREEN_CYC cycles of green
module emergency_preempt_ctrl #(
  parameter int GREEN_CYC     = 20,
  parameter int YELLOW_CYC    = 4,
  parameter int ALLRED_CYC    = 2,
  parameter int PREEMPT_CYC   = 30,
  parameter int MIN_GREEN_CYC = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       amb_ns,
  input  logic       amb_ew,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       preempt_active,
  output logic       preempt_dir,
  output logic [7:0] preempt_count
);
  localparam int MAX_A = GREEN_CYC > YELLOW_CYC ? GREEN_CYC : YELLOW_CYC;
  localparam int MAX_B = ALLRED_CYC > PREEMPT_CYC ? ALLRED_CYC : PREEMPT_CYC;
  localparam int MAX_D = MAX_A > MAX_B ? MAX_A : MAX_B;
  localparam int TW = MAX_D > 1 ? $clog2(MAX_D) : 1;
  localparam logic [TW-1:0] G_L = TW'(GREEN_CYC - 1);
  localparam logic [TW-1:0] Y_L = TW'(YELLOW_CYC - 1);
  localparam logic [TW-1:0] A_L = TW'(ALLRED_CYC - 1);
  localparam logic [TW-1:0] P_L = TW'(PREEMPT_CYC - 1);

  typedef enum logic [2:0] {ALLRED_A, NS_GREEN, NS_YELLOW, ALLRED_B, EW_GREEN, EW_YELLOW, PREEMPT} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d, load;
  logic            pend_ns_q, pend_ns_d, pend_ew_q, pend_ew_d;
  logic            pdir_q, pdir_d, active_q, active_d;
  logic [7:0]      count_q, count_d;
  logic [2:0]      ns_q, ns_d, ew_q, ew_d;
  logic            done, hold, enter, min_ok;

  assign done = timer_q == '0;
  assign hold = state_q == PREEMPT && (pdir_q ? amb_ew : amb_ns);

`ifdef PREEMPT_MIN_GREEN_EN
  assign min_ok = int'(timer_q) + MIN_GREEN_CYC <= GREEN_CYC;
`else
  localparam int unused_min_green = MIN_GREEN_CYC;
  assign min_ok = 1'b1;
`endif

  // next state: dwell expiry, truncation of the opposite green, NS wins ties
  always_comb begin
    state_d = state_q;
    case (state_q)
      ALLRED_A:  state_d = !done ? ALLRED_A : pend_ns_q ? PREEMPT : NS_GREEN;
      NS_GREEN:  state_d = pend_ns_q ? PREEMPT : (done || (pend_ew_q && min_ok)) ? NS_YELLOW : NS_GREEN;
      NS_YELLOW: state_d = done ? ALLRED_B : NS_YELLOW;
      ALLRED_B:  state_d = !done ? ALLRED_B : pend_ew_q ? PREEMPT : EW_GREEN;
      EW_GREEN:  state_d = pend_ns_q ? ((done || min_ok) ? EW_YELLOW : EW_GREEN) :
                           pend_ew_q ? PREEMPT : done ? EW_YELLOW : EW_GREEN;
      EW_YELLOW: state_d = done ? ALLRED_A : EW_YELLOW;
      PREEMPT:   state_d = (done && !hold) ? (pdir_q ? EW_YELLOW : NS_YELLOW) : PREEMPT;
      default:   state_d = ALLRED_A;
    endcase
  end

  // dwell timer, request latches, counters and lights decoded from the next state
  always_comb begin
    enter     = state_d == PREEMPT && state_q != PREEMPT;
    pdir_d    = enter ? (state_q == ALLRED_B || state_q == EW_GREEN) : pdir_q;
    load      = (state_d == NS_GREEN || state_d == EW_GREEN) ? G_L :
                (state_d == NS_YELLOW || state_d == EW_YELLOW) ? Y_L :
                state_d == PREEMPT ? P_L : A_L;
    timer_d   = state_d != state_q ? load : hold ? P_L : timer_q - TW'(1);
    pend_ns_d = !(enter && !pdir_d) && (pend_ns_q || (amb_ns && !(state_q == PREEMPT && !pdir_q)));
    pend_ew_d = !(enter && pdir_d) && (pend_ew_q || (amb_ew && !(state_q == PREEMPT && pdir_q)));
    count_d   = (enter && count_q != 8'hFF) ? count_q + 8'd1 : count_q;
    active_d  = state_d == PREEMPT;
    ns_d      = (state_d == NS_GREEN || (active_d && !pdir_d)) ? 3'b001 : state_d == NS_YELLOW ? 3'b010 : 3'b100;
    ew_d      = (state_d == EW_GREEN || (active_d && pdir_d)) ? 3'b001 : state_d == EW_YELLOW ? 3'b010 : 3'b100;
  end

  // state and output registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q   <= ALLRED_A;
      timer_q   <= A_L;
      pend_ns_q <= 1'b0;
      pend_ew_q <= 1'b0;
      pdir_q    <= 1'b0;
      active_q  <= 1'b0;
      count_q   <= 8'd0;
      ns_q      <= 3'b100;
      ew_q      <= 3'b100;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      pend_ns_q <= pend_ns_d;
      pend_ew_q <= pend_ew_d;
      pdir_q    <= pdir_d;
      active_q  <= active_d;
      count_q   <= count_d;
      ns_q      <= ns_d;
      ew_q      <= ew_d;
    end

  assign ns_light       = ns_q;
  assign ew_light       = ew_q;
  assign preempt_active = active_q;
  assign preempt_dir    = pdir_q;
  assign preempt_count  = count_q;
endmodule

// File: tb/tb_emergency_preempt_ctrl.sv
// tb_emergency_preempt_ctrl: directed scenarios checked against a phase/elapsed-time model every cycle
module tb_emergency_preempt_ctrl;
  localparam int G = 20, Y = 4, A = 2, P = 30, MG = 5;

  logic       clk = 1'b0, reset = 1'b1, amb_ns = 1'b0, amb_ew = 1'b0;
  logic [2:0] ns_light, ew_light;
  logic       preempt_active, preempt_dir;
  logic [7:0] preempt_count;
  int         n_chk = 0, n_fail = 0;

  emergency_preempt_ctrl #(.GREEN_CYC(G), .YELLOW_CYC(Y), .ALLRED_CYC(A), .PREEMPT_CYC(P), .MIN_GREEN_CYC(MG)) dut (
    .clk(clk), .reset(reset), .amb_ns(amb_ns), .amb_ew(amb_ew),
    .ns_light(ns_light), .ew_light(ew_light), .preempt_active(preempt_active),
    .preempt_dir(preempt_dir), .preempt_count(preempt_count)
  );

  always #5 clk = ~clk;

  // model: head that last owned green, stage (0 green, 1 yellow, 2 all-red), cycles elapsed in stage
  int m_dir, m_stage, m_el, m_cnt, m_pdir;
  bit m_pre;
  bit m_pend [2];

  task automatic m_reset();
    m_dir = 1; m_stage = 2; m_el = 0; m_pre = 0; m_cnt = 0; m_pdir = 0;
    m_pend[0] = 0; m_pend[1] = 0;
  endtask

  task automatic m_step(input bit a_ns, input bit a_ew);
    bit a [2];
    bit np [2];
    int want, o, ent;
    bit mg;
    a[0] = a_ns; a[1] = a_ew;
    for (int i = 0; i < 2; i++) np[i] = m_pend[i] | (a[i] && !(m_pre && m_dir == i));
    want = m_pend[0] ? 0 : m_pend[1] ? 1 : -1;
    o = 1 - m_dir;
    ent = -1;
`ifdef PREEMPT_MIN_GREEN_EN
    mg = m_el + 1 >= MG;
`else
    mg = 1;
`endif
    if (m_stage == 0 && m_pre) begin
      if (a[m_dir]) m_el = 0;
      else if (m_el + 1 == P) begin m_stage = 1; m_pre = 0; m_el = 0; end
      else m_el++;
    end else if (m_stage == 0) begin
      if (want == m_dir) ent = m_dir;
      else if ((want == o && mg) || m_el + 1 == G) begin m_stage = 1; m_el = 0; end
      else m_el++;
    end else if (m_stage == 1) begin
      if (m_el + 1 == Y) begin m_stage = 2; m_el = 0; end
      else m_el++;
    end else begin
      if (m_el + 1 == A) begin
        m_dir = o; m_stage = 0; m_el = 0;
        if (m_pend[o]) ent = o;
      end else m_el++;
    end
    m_pend = np;
    if (ent >= 0) begin
      m_pre = 1; m_el = 0; m_pend[ent] = 0; m_pdir = ent;
      if (m_cnt < 255) m_cnt++;
    end
  endtask

  function automatic logic [2:0] m_head(input int d);
    return (m_stage == 0 && m_dir == d) ? 3'b001 : (m_stage == 1 && m_dir == d) ? 3'b010 : 3'b100;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(posedge clk or posedge reset)
    if (reset) m_reset();
    else m_step(amb_ns, amb_ew);

  always @(negedge clk) begin
    chk("model ns_light", ns_light, m_head(0));
    chk("model ew_light", ew_light, m_head(1));
    chk("model preempt_active", preempt_active, m_pre);
    chk("model preempt_dir", preempt_dir, m_pdir);
    chk("model preempt_count", preempt_count, m_cnt);
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    adv(2);
    chk("reset ns", ns_light, 3'b100);
    chk("reset ew", ew_light, 3'b100);
    chk("reset active", preempt_active, 0);
    chk("reset dir", preempt_dir, 0);
    chk("reset count", preempt_count, 0);
    reset = 1'b0;
    adv(1);  chk("allred hold", ns_light, 3'b100);
    adv(1);  chk("ns green start", ns_light, 3'b001);
             chk("ew red at ns green", ew_light, 3'b100);
    adv(19); chk("ns green last", ns_light, 3'b001);
    adv(1);  chk("ns yellow", ns_light, 3'b010);
    adv(4);  chk("allred b ns", ns_light, 3'b100);
             chk("allred b ew", ew_light, 3'b100);
    adv(2);  chk("ew green", ew_light, 3'b001);
    adv(20); chk("ew yellow", ew_light, 3'b010);
    adv(6);  chk("period 52", ns_light, 3'b001);
    // EW request at cycle 5 of NS green
    adv(4);  amb_ew = 1'b1;
    adv(1);  amb_ew = 1'b0;
    chk("pending only", ns_light, 3'b001);
    chk("pending inactive", preempt_active, 0);
    adv(1);  chk("truncate yellow", ns_light, 3'b010);
    adv(4);  chk("truncate allred", ew_light, 3'b100);
    adv(2);  chk("ew preempt green", ew_light, 3'b001);
             chk("ew preempt active", preempt_active, 1);
             chk("ew preempt dir", preempt_dir, 1);
             chk("ew preempt count", preempt_count, 1);
    adv(29); chk("ew preempt held", preempt_active, 1);
    adv(1);  chk("ew preempt exit", ew_light, 3'b010);
             chk("exit inactive", preempt_active, 0);
    adv(6);  chk("back to ns", ns_light, 3'b001);
    // NS request while NS green, then reload 10 cycles in
    amb_ns = 1'b1;
    adv(1);  amb_ns = 1'b0;
    adv(1);  chk("ns preempt active", preempt_active, 1);
             chk("ns preempt dir", preempt_dir, 0);
             chk("ns preempt count", preempt_count, 2);
    adv(9);  amb_ns = 1'b1;
    adv(1);  amb_ns = 1'b0;
    adv(29); chk("reload held", ns_light, 3'b001);
    adv(1);  chk("reload exit", ns_light, 3'b010);
             chk("reload no recount", preempt_count, 2);
    adv(6);  chk("ew normal", ew_light, 3'b001);
             chk("ew normal inactive", preempt_active, 0);
    // simultaneous requests during EW green
    adv(3);  amb_ns = 1'b1; amb_ew = 1'b1;
    adv(1);  amb_ns = 1'b0; amb_ew = 1'b0;
    adv(1);  chk("sim ew yellow", ew_light, 3'b010);
    adv(6);  chk("sim ns first", ns_light, 3'b001);
             chk("sim ns dir", preempt_dir, 0);
             chk("sim ns count", preempt_count, 3);
    adv(30); chk("sim ns yellow", ns_light, 3'b010);
    adv(6);  chk("sim ew second", ew_light, 3'b001);
             chk("sim ew dir", preempt_dir, 1);
             chk("sim ew count", preempt_count, 4);
    // asynchronous reset in the middle of a preemption
    adv(10);
    #2 reset = 1'b1;
    #1;
    chk("async ns", ns_light, 3'b100);
    chk("async ew", ew_light, 3'b100);
    chk("async active", preempt_active, 0);
    chk("async dir", preempt_dir, 0);
    chk("async count", preempt_count, 0);
    adv(3);
    reset = 1'b0;
    // back-to-back alternating preemptions to reach saturation
    amb_ns = 1'b1;
    adv(1);  amb_ns = 1'b0;
    for (int i = 0; i < 9400; i++) begin
      amb_ns = m_pre && m_pdir == 1;
      amb_ew = m_pre && m_pdir == 0;
      adv(1);
    end
    amb_ns = 1'b0; amb_ew = 1'b0;
    adv(1);
    chk("count saturates", preempt_count, 8'd255);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
